// File: rtl/seq_stage_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : seq_stage_sequencer_if
// Brief   : Datapath/memory-side signal bundle of the SEQ stage sequencer.
// Rev     : 1.0  initial release
// ============================================================================
interface seq_stage_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic [3:0]       icode;
    logic             instr_valid;
    logic             imem_error;
    logic             mem_ready;
    logic             dmem_error;
    logic             fetch_en;
    logic             decode_en;
    logic             execute_en;
    logic             memory_en;
    logic             writeback_en;
    logic             pc_update_en;
    logic [2:0]       stage;
    logic [2:0]       stat;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    // Sequencer side
    modport slave (
        input  start, icode, instr_valid, imem_error, mem_ready, dmem_error,
        output fetch_en, decode_en, execute_en, memory_en, writeback_en,
               pc_update_en, stage, stat, busy, halted, instr_count
    );

    // Datapath / control-host side
    modport master (
        output start, icode, instr_valid, imem_error, mem_ready, dmem_error,
        input  fetch_en, decode_en, execute_en, memory_en, writeback_en,
               pc_update_en, stage, stat, busy, halted, instr_count
    );
endinterface

`default_nettype wire

// File: rtl/seq_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : seq_stage_sequencer
// Brief   : Moore controller stepping the Y86-64 SEQ datapath one stage per
//           cycle; optional macro SEQ_SINGLE_STEP_EN returns to IDLE per instr.
// Rev     : 1.0  initial release
// ============================================================================
module seq_stage_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_stage_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        PCUPD     = 3'd6,
        STOP      = 3'd7
    } state_t;

    localparam logic [2:0] STAT_AOK  = 3'd1;
    localparam logic [2:0] STAT_HLT  = 3'd2;
    localparam logic [2:0] STAT_ADR  = 3'd3;
    localparam logic [2:0] STAT_INS  = 3'd4;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_stat;
    logic [2:0]       w_next_stat;
    logic [CNT_W-1:0] r_count;
    logic             w_count_inc;
    logic [3:0]       r_icode;
    logic [3:0]       w_next_icode;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_next_wait;
    logic             w_mem_op;

    // mrmovq, rmmovq, call, ret, pushq, popq touch data memory
    assign w_mem_op = r_icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

    always_comb begin
        w_next_state = r_state;
        w_next_stat  = r_stat;
        w_count_inc  = 1'b0;
        w_next_icode = r_icode;
        w_next_wait  = r_wait_cnt;
        case (r_state)
            IDLE: begin
                if (bus.start) w_next_state = FETCH;
            end
            FETCH: begin
                if (bus.imem_error) begin
                    w_next_state = STOP;
                    w_next_stat  = STAT_ADR;
                end else if (!bus.instr_valid) begin
                    w_next_state = STOP;
                    w_next_stat  = STAT_INS;
                end else if (bus.icode == 4'h0) begin
                    w_next_state = STOP;
                    w_next_stat  = STAT_HLT;
                    w_count_inc  = 1'b1;
                end else begin
                    w_next_icode = bus.icode;
                    w_next_state = DECODE;
                end
            end
            DECODE:  w_next_state = EXECUTE;
            EXECUTE: begin
                w_next_state = MEMORY;
                w_next_wait  = 8'd0;
            end
            MEMORY: begin
                if (!w_mem_op) begin
                    w_next_state = WRITEBACK;
                end else if (bus.mem_ready) begin
                    // A response arriving on the last allowed cycle still wins over the timeout
                    if (bus.dmem_error) begin
                        w_next_state = STOP;
                        w_next_stat  = STAT_ADR;
                    end else begin
                        w_next_state = WRITEBACK;
                    end
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_next_state = STOP;
                    w_next_stat  = STAT_ADR;
                end else begin
                    w_next_wait = r_wait_cnt + 8'd1;
                end
            end
            WRITEBACK: w_next_state = PCUPD;
            PCUPD: begin
                w_count_inc = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
                w_next_state = IDLE;
`else
                w_next_state = FETCH;
`endif
            end
            STOP:    w_next_state = STOP;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_stat     <= STAT_AOK;
            r_count    <= '0;
            r_icode    <= 4'h0;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_next_state;
            r_stat     <= w_next_stat;
            r_icode    <= w_next_icode;
            r_wait_cnt <= w_next_wait;
            if (w_count_inc) r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.fetch_en     = (r_state == FETCH);
    assign bus.decode_en    = (r_state == DECODE);
    assign bus.execute_en   = (r_state == EXECUTE);
    assign bus.memory_en    = (r_state == MEMORY);
    assign bus.writeback_en = (r_state == WRITEBACK);
    assign bus.pc_update_en = (r_state == PCUPD);
    assign bus.stage        = r_state;
    assign bus.stat         = r_stat;
    assign bus.busy         = (r_state != IDLE) && (r_state != STOP);
    assign bus.halted       = (r_state == STOP);
    assign bus.instr_count  = r_count;
endmodule

`default_nettype wire

// File: tb/tb_seq_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_stage_sequencer
// Brief   : Scoreboard bench for seq_stage_sequencer; honours SEQ_SINGLE_STEP_EN.
// Rev     : 1.0  initial release
// ============================================================================
module tb_seq_stage_sequencer;
    localparam int CNT_W       = 32;
    localparam int MEM_TIMEOUT = 15;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3;
    localparam logic [2:0] S_MEMORY = 3'd4, S_WRITEBACK = 3'd5, S_PCUPD = 3'd6, S_STOP = 3'd7;

    typedef struct {
        logic [2:0]       stage;
        logic [2:0]       stat;
        logic [CNT_W-1:0] count;
    } exp_t;

    logic clk;
    logic rst_n;

    seq_stage_sequencer_if #(.CNT_W(CNT_W)) bus ();

    seq_stage_sequencer #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    logic [2:0]       m_stat;
    logic [CNT_W-1:0] m_count;
    bit               m_idle;
    logic [3:0]       mem_ops[6] = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void check(string name, exp_t e);
        logic [5:0] en_exp, en_act;
        logic       busy_exp, halted_exp;
        en_exp     = (e.stage >= S_FETCH && e.stage <= S_PCUPD) ? 6'(1 << (e.stage - 3'd1)) : 6'd0;
        busy_exp   = (e.stage != S_IDLE) && (e.stage != S_STOP);
        halted_exp = (e.stage == S_STOP);
        en_act     = {bus.pc_update_en, bus.writeback_en, bus.memory_en,
                      bus.execute_en, bus.decode_en, bus.fetch_en};
        n_checks++;
        if (bus.stage === e.stage && bus.stat === e.stat && bus.instr_count === e.count &&
            en_act === en_exp && bus.busy === busy_exp && bus.halted === halted_exp)
            n_pass++;
        else
            $display("FAIL %s @%0t: got stage=%0d stat=%0d count=%0d en=%b busy=%b halted=%b, want stage=%0d stat=%0d count=%0d en=%b busy=%b halted=%b",
                     name, $time, bus.stage, bus.stat, bus.instr_count, en_act, bus.busy, bus.halted,
                     e.stage, e.stat, e.count, en_exp, busy_exp, halted_exp);
    endfunction

    // Monitor: one expected snapshot per cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("stage_seq", e);
            end
        end
    end

    task automatic step(input logic [2:0] st, input logic s, input logic [3:0] ic, input logic v,
                        input logic ie, input logic mr, input logic de);
        exp_t e;
        e.stage = st;
        e.stat  = m_stat;
        e.count = m_count;
        sb_q.push_back(e);
        bus.start       = s;
        bus.icode       = ic;
        bus.instr_valid = v;
        bus.imem_error  = ie;
        bus.mem_ready   = mr;
        bus.dmem_error  = de;
        @(posedge clk);
        #1;
    endtask

    task automatic step_junk(input logic [2:0] st, input logic s);
        step(st, s, 4'($urandom_range(0, 15)), rb(), rb(), rb(), rb());
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        m_stat  = 3'd1;
        m_count = '0;
        m_idle  = 1'b1;
        step_junk(S_IDLE, rb());
        rst_n = 1'b1;
    endtask

    task automatic begin_run();
        int n = $urandom_range(0, 2);
        repeat (n) step_junk(S_IDLE, 1'b0);
        step_junk(S_IDLE, 1'b1);
        m_idle = 1'b0;
    endtask

    task automatic stop_phase();
        repeat (3) step_junk(S_STOP, 1'b1);
    endtask

    // One instruction at transaction level. delay<0 means mem_ready never comes;
    // reset_at>=0 drops rst_n mid-cycle during that MEMORY wait cycle.
    task automatic exec(input logic [3:0] ic, input logic v, input logic ie, input int delay,
                        input logic de, input int reset_at, output int res);
        int   waits;
        bit   timeout;
        exp_t e;
        if (m_idle) begin_run();
        step(S_FETCH, rb(), ic, v, ie, rb(), rb());
        res = 1;
        if (ie) begin m_stat = 3'd3; return; end
        if (!v) begin m_stat = 3'd4; return; end
        if (ic == 4'h0) begin m_stat = 3'd2; m_count++; return; end
        step_junk(S_DECODE, rb());
        step_junk(S_EXECUTE, rb());
        if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
            timeout = (delay < 0) || (delay >= MEM_TIMEOUT);
            waits   = timeout ? MEM_TIMEOUT : delay + 1;
            for (int k = 0; k < waits; k++) begin
                if (k == reset_at) begin
                    bus.mem_ready  = 1'b0;
                    bus.dmem_error = rb();
                    #2;
                    rst_n   = 1'b0;
                    #1;
                    m_stat  = 3'd1;
                    m_count = '0;
                    m_idle  = 1'b1;
                    e.stage = S_IDLE;
                    e.stat  = m_stat;
                    e.count = m_count;
                    check("async_reset", e);
                    @(posedge clk);
                    #1;
                    res = 2;
                    return;
                end
                step(S_MEMORY, rb(), 4'($urandom_range(0, 15)), rb(), rb(), (k == delay),
                     (k == delay) ? de : rb());
            end
            if (timeout || de) begin m_stat = 3'd3; return; end
        end else begin
            step_junk(S_MEMORY, rb());
        end
        step_junk(S_WRITEBACK, rb());
        step_junk(S_PCUPD, rb());
        m_count++;
`ifdef SEQ_SINGLE_STEP_EN
        m_idle = 1'b1;
`endif
        res = 0;
    endtask

    task automatic random_session();
        int n, res, kind;
        do_reset();
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++)
            exec(4'($urandom_range(1, 11)), 1'b1, 1'b0, $urandom_range(0, 4), 1'b0, -1, res);
        kind = $urandom_range(0, 4);
        case (kind)
            0: exec(4'h0, 1'b1, 1'b0, 0, 1'b0, -1, res);
            1: exec(4'($urandom_range(0, 15)), rb(), 1'b1, 0, 1'b0, -1, res);
            2: exec(4'($urandom_range(0, 15)), 1'b0, 1'b0, 0, 1'b0, -1, res);
            3: exec(mem_ops[$urandom_range(0, 5)], 1'b1, 1'b0, $urandom_range(0, 4), 1'b1, -1, res);
            default: exec(mem_ops[$urandom_range(0, 5)], 1'b1, 1'b0, -1, 1'b0, -1, res);
        endcase
        stop_phase();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit, sim time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int res;
        rst_n           = 1'b1;
        m_stat          = 3'd1;
        m_count         = '0;
        m_idle          = 1'b1;
        bus.start       = 1'b0;
        bus.icode       = 4'h0;
        bus.instr_valid = 1'b0;
        bus.imem_error  = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.dmem_error  = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then hold start low
        do_reset();
        repeat (5) step_junk(S_IDLE, 1'b0);

        // Nop stream ending in halt
        exec(4'h1, 1'b1, 1'b0, 0, 1'b0, -1, res);
        exec(4'h1, 1'b1, 1'b0, 0, 1'b0, -1, res);
        exec(4'h0, 1'b1, 1'b0, 0, 1'b0, -1, res);
        stop_phase();

        // mrmovq with mem_ready three cycles late
        do_reset();
        exec(4'h5, 1'b1, 1'b0, 3, 1'b0, -1, res);
        exec(4'h0, 1'b1, 1'b0, 0, 1'b0, -1, res);
        stop_phase();

        // mrmovq that never gets mem_ready
        do_reset();
        exec(4'h5, 1'b1, 1'b0, -1, 1'b0, -1, res);
        stop_phase();

        // imem_error outranks invalid instruction
        do_reset();
        exec(4'h1, 1'b0, 1'b1, 0, 1'b0, -1, res);
        stop_phase();

        // Illegal instruction
        do_reset();
        exec(4'h1, 1'b0, 1'b0, 0, 1'b0, -1, res);
        stop_phase();

        // Data-memory fault on pushq
        do_reset();
        exec(4'hA, 1'b1, 1'b0, 1, 1'b1, -1, res);
        stop_phase();

        // Async reset during a memory stall, then a clean restart
        do_reset();
        exec(4'h2, 1'b1, 1'b0, 0, 1'b0, -1, res);
        exec(4'h5, 1'b1, 1'b0, -1, 1'b0, 2, res);
        step_junk(S_IDLE, rb());
        rst_n = 1'b1;
        exec(4'h8, 1'b1, 1'b0, 2, 1'b0, -1, res);
        exec(4'h6, 1'b1, 1'b0, 0, 1'b0, -1, res);
        exec(4'h0, 1'b1, 1'b0, 0, 1'b0, -1, res);
        stop_phase();

        repeat (20) random_session();

        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/seq_stage_sequencer.md
Name: seq_stage_sequencer

Overview:
- Moore-style controller that sequences the Y86-64 SEQ datapath one stage per cycle: fetch, decode, execute, memory, writeback, PC update.
- Drives one-hot stage enables into those blocks, stretches the memory stage on the data-memory handshake, and owns the architectural status (Stat) register.
- Sits above fetch/decode/execute/memory and replaces the free-running clock stepping used by the stage benches.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- MEM_TIMEOUT, 15, max cycles MEMORY waits for mem_ready before ADR fault (1..255)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  launch execution from IDLE (level, sampled in IDLE)
- icode  input  4  instruction code from fetch, valid in FETCH
- instr_valid  input  1  fetch decoded a legal icode/ifun
- imem_error  input  1  fetch address out of range
- mem_ready  input  1  data-memory access complete
- dmem_error  input  1  data-memory address fault, qualified by mem_ready
- fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_update_en  output  1 each  stage enables
- stage  output  3  current state encoding
- stat  output  3  Y86 status: 1 AOK, 2 HLT, 3 ADR, 4 INS
- busy  output  1  state not IDLE/STOP
- halted  output  1  state == STOP
- instr_count  output  CNT_W  retired instructions

Behaviour:
- States/encoding: IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, MEMORY 4, WRITEBACK 5, PCUPD 6, STOP 7.
- Reset (async on rst_n low, any state, mid-instruction included):
  - state IDLE, all enables 0, stat 1, instr_count 0, latched icode 0, wait counter 0.
- Enables: exactly one asserted, combinationally from state. None in IDLE/STOP.
- IDLE -> FETCH when start=1.
- FETCH, single cycle. Priority order:
  - imem_error -> STOP, stat 3.
  - else !instr_valid -> STOP, stat 4.
  - else icode==0 (halt) -> STOP, stat 2, instr_count +1.
  - else latch icode -> DECODE.
- DECODE -> EXECUTE -> MEMORY, one cycle each.
- MEMORY:
  - Memory icodes (4,5,8,9,A,B) wait for mem_ready.
  - When mem_ready=1: dmem_error=1 -> STOP stat 3; otherwise -> WRITEBACK.
  - Wait counter clears on MEMORY entry. If MEM_TIMEOUT cycles elapse in MEMORY without mem_ready -> STOP stat 3.
  - Other icodes: one cycle, mem_ready ignored.
- WRITEBACK -> PCUPD.
- PCUPD: instr_count +1 (wraps modulo 2^CNT_W), -> FETCH.
- STOP is sticky until reset; stat, instr_count and halted hold. start ignored.
- Nominal latency: 6 cycles/instruction; memory instructions 6 + (cycles until mem_ready).
- mem_ready and dmem_error outside MEMORY are ignored.

Optional Feature:
- SEQ_SINGLE_STEP_EN defined:
  - PCUPD -> IDLE instead of FETCH, so each start pulse executes exactly one instruction.
  - busy drops after every instruction.
- Undefined: PCUPD -> FETCH, continuous execution until STOP.

Test Plan:
- Reset state: rst_n=0 -> stage=0, stat=1, instr_count=0, all enables 0; release and hold start=0 for 5 cycles -> stays IDLE.
- Nop stream:
  - Stimulus: start=1, icode=1, instr_valid=1.
  - Response: stage steps 1,2,3,4,5,6,1 on successive cycles. instr_count=1 on the cycle stage returns to 1, then 2 after 6 more cycles.
- mrmovq stall:
  - Stimulus: icode=5, mem_ready raised 3 cycles after MEMORY entry.
  - Response: memory_en held 4 cycles, then WRITEBACK.
  - Variant: mem_ready never asserted -> STOP with stat=3 after 15 cycles.
- Halt and faults:
  - icode=0 -> stage=7, stat=2, halted=1, instr_count +1, enables 0; start ignored afterwards.
  - imem_error=1 with instr_valid=0 -> stat=3 (imem_error has priority).
  - instr_valid=0 alone -> stat=4.
  - dmem_error=1 with mem_ready on icode=A -> stat=3.
- Reset mid-MEMORY: assert rst_n=0 asynchronously between clock edges during a stall -> outputs return to reset values immediately; restart runs normally.
- SEQ_SINGLE_STEP_EN build: two start pulses -> instr_count=2, stage=0 after each instruction.
